// File: rtl/instruction_fetch.sv
// PC-holding fetch stage: REQ/ready handshake to instruction memory, next-PC selection, Jal link.
// Optional misaligned-target trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic [31:0] Instruction,
    output logic        instr_valid,
    output logic [31:0] PC_plus_4,
    input  logic [31:0] Addr_Result,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    output logic [31:0] link_addr,
    output logic        trap
);

`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] link_q, link_d;
    logic        trap_q, trap_d;

    logic [31:0] pc_plus_4;
    logic [31:0] jump_target;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;
    logic        take_branch;
    logic        misaligned;
    logic        trap_taken;

    assign pc_plus_4   = pc_q + 32'd4;
    assign jump_target = {pc_plus_4[31:28], instr_q[25:0], 2'b00};
    assign take_branch = (Branch & Zero) | (nBranch & ~Zero);

    // Priority: Jr > Jmp/Jal > taken branch > sequential.
    always_comb begin
        redirect_pc = pc_plus_4;
        if (Jr) begin
            redirect_pc = Read_data_1;
        end else if (Jmp | Jal) begin
            redirect_pc = jump_target;
        end else if (take_branch) begin
            redirect_pc = Addr_Result;
        end
    end

    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign trap_taken = TRAP_EN && misaligned;
    assign next_pc    = trap_taken ? TRAP_VECTOR : {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        link_d  = link_q;
        trap_d  = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                    trap_d  = trap_taken;
                    // A trapped jal does not link.
                    if (Jal && !trap_taken) begin
                        link_d = pc_plus_4;
                    end
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            link_q  <= 32'd0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
            trap_q  <= trap_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_VALID);
    assign Instruction = instr_q;
    assign PC_plus_4   = pc_plus_4;
    assign link_addr   = link_q;
    assign trap        = trap_q;

endmodule
